// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a PHT of saturating counters
// (bimodal or gshare). Lookup is combinational; training happens at branch resolve.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_IDX_W  = 4,
  parameter int PHT_IDX_W  = 8,
  parameter int GHR_WIDTH  = 8,
  parameter int CTR_WIDTH  = 2,
  parameter int GSHARE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  output logic [GHR_WIDTH-1:0]  pred_ghr,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_is_jump,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [DATA_WIDTH-1:0] upd_pred_target,
  input  logic [GHR_WIDTH-1:0]  upd_ghr,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           branch_count,
  output logic [31:0]           mispredict_count
);

  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = DATA_WIDTH - BTB_IDX_W - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  logic                  btb_valid  [BTB_N];
  logic [TAG_W-1:0]      btb_tag    [BTB_N];
  logic [DATA_WIDTH-1:0] btb_target [BTB_N];
  logic                  btb_jump   [BTB_N];
  logic [CTR_WIDTH-1:0]  pht_ctr    [PHT_N];

  logic [GHR_WIDTH-1:0]  ghr_reg;
  logic [31:0]           branch_count_reg;
  logic [31:0]           mispredict_count_reg;

  logic [BTB_IDX_W-1:0]  look_btb_idx;
  logic [TAG_W-1:0]      look_tag;
  logic [PHT_IDX_W-1:0]  look_pht_idx;
  logic [CTR_WIDTH-1:0]  look_ctr;
  logic                  btb_hit;

  logic [BTB_IDX_W-1:0]  upd_btb_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic [PHT_IDX_W-1:0]  upd_pht_idx;
  logic                  upd_fire;
  logic                  btb_wr;
  logic                  pht_wr;
  logic                  unused_pc_bits;

  // Instruction addresses are word aligned, so the low two PC bits never index anything.
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup path
  assign look_btb_idx = if_pc[BTB_IDX_W+1:2];
  assign look_tag     = if_pc[DATA_WIDTH-1:BTB_IDX_W+2];
  assign look_pht_idx = if_pc[PHT_IDX_W+1:2] ^ ((GSHARE != 0) ? PHT_IDX_W'(ghr_reg) : '0);
  assign look_ctr     = pht_ctr[look_pht_idx];
  assign btb_hit      = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);
  assign pred_taken   = btb_hit && (btb_jump[look_btb_idx] || look_ctr[CTR_WIDTH-1]);
  assign pred_target  = pred_taken ? btb_target[look_btb_idx] : (if_pc + DATA_WIDTH'(4));
  assign pred_ghr     = ghr_reg;

  // Resolve path; the PHT is trained with the history the instruction was predicted under
  assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag     = upd_pc[DATA_WIDTH-1:BTB_IDX_W+2];
  assign upd_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ ((GSHARE != 0) ? PHT_IDX_W'(upd_ghr) : '0);
  assign upd_fire    = upd_valid && (upd_is_branch || upd_is_jump);
  assign btb_wr      = upd_fire && upd_taken;
  assign pht_wr      = upd_fire && upd_is_branch;

  assign mispredict  = upd_fire &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = !upd_valid ? '0 :
                       (upd_taken ? upd_target : (upd_pc + DATA_WIDTH'(4)));

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BTB_N; gi++) begin : g_btb
      logic                  valid_reg;
      logic                  jump_reg;
      logic [TAG_W-1:0]      tag_reg;
      logic [DATA_WIDTH-1:0] target_reg;
      logic                  wr_sel;

      assign wr_sel = btb_wr && (upd_btb_idx == BTB_IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (wr_sel) begin
          valid_reg <= 1'b1;
        end
      end

      // Payload needs no reset: it is only observed through a set valid bit.
      always_ff @(posedge clk) begin
        if (!rst && wr_sel) begin
          tag_reg    <= upd_tag;
          target_reg <= upd_target;
          jump_reg   <= upd_is_jump;
        end
      end

      assign btb_valid[gi]  = valid_reg;
      assign btb_tag[gi]    = tag_reg;
      assign btb_target[gi] = target_reg;
      assign btb_jump[gi]   = jump_reg;
    end

    for (gi = 0; gi < PHT_N; gi++) begin : g_pht
      logic [CTR_WIDTH-1:0] ctr_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_reg <= CTR_INIT;
        end else if (pht_wr && (upd_pht_idx == PHT_IDX_W'(gi))) begin
          if (upd_taken) begin
            if (ctr_reg != CTR_MAX) ctr_reg <= ctr_reg + CTR_WIDTH'(1);
          end else begin
            if (ctr_reg != '0) ctr_reg <= ctr_reg - CTR_WIDTH'(1);
          end
        end
      end

      assign pht_ctr[gi] = ctr_reg;
    end
  endgenerate

  // History only advances on resolved conditional branches, never speculatively.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg              <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (pht_wr) ghr_reg <= (ghr_reg << 1) | GHR_WIDTH'(upd_taken);
      if (upd_fire) branch_count_reg <= branch_count_reg + 32'd1;
      if (mispredict) mispredict_count_reg <= mispredict_count_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance for BTB/counter/jump behaviour
// and a gshare instance (2-bit history) for the alternating-pattern case.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [7:0]  upd_ghr_b;
  logic [1:0]  upd_ghr_g;

  logic        b_pred_taken, b_mispredict;
  logic [31:0] b_pred_target, b_redirect_pc, b_branch_count, b_mispredict_count;
  logic [7:0]  b_pred_ghr;
  logic        g_pred_taken, g_mispredict;
  logic [31:0] g_pred_target, g_redirect_pc, g_branch_count, g_mispredict_count;
  logic [1:0]  g_pred_ghr;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  branch_predictor #(.GSHARE(0)) u_bim (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target), .pred_ghr(b_pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr_b),
    .mispredict(b_mispredict), .redirect_pc(b_redirect_pc),
    .branch_count(b_branch_count), .mispredict_count(b_mispredict_count)
  );

  branch_predictor #(.GSHARE(1), .GHR_WIDTH(2)) u_gsh (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(g_pred_taken), .pred_target(g_pred_target), .pred_ghr(g_pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr_g),
    .mispredict(g_mispredict), .redirect_pc(g_redirect_pc),
    .branch_count(g_branch_count), .mispredict_count(g_mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt, input logic [1:0] gg);
    upd_valid = v; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    upd_ghr_b = 8'h00; upd_ghr_g = gg;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
  endtask

  // Alternating T/N at 0x100 under gshare: bit k is iteration k.
  logic [7:0] gs_taken = 8'b0101_0101;
  logic [7:0] gs_pred  = 8'b0101_0000;
  logic [7:0] gs_mp    = 8'b0000_0101;
  logic [1:0] gs_ghr [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

  initial begin
    rst = 1'b1;
    if_pc = 32'h40;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_pred_taken", 32'(b_pred_taken), 32'd0);
    check("rst_pred_target", b_pred_target, 32'h44);
    check("rst_pred_ghr", 32'(b_pred_ghr), 32'd0);
    check("rst_branch_count", b_branch_count, 32'd0);
    check("rst_mispredict_count", b_mispredict_count, 32'd0);
    check("rst_mispredict", 32'(b_mispredict), 32'd0);
    check("rst_redirect", b_redirect_pc, 32'd0);

    // First taken resolve of the branch at 0x40
    @(negedge clk);
    set_upd(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h44, 2'd0);
    #1;
    check("a_mispredict", 32'(b_mispredict), 32'd1);
    check("a_redirect", b_redirect_pc, 32'h10);
    check("a_no_bypass", 32'(b_pred_taken), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("a_pred_taken", 32'(b_pred_taken), 32'd1);
    check("a_pred_target", b_pred_target, 32'h10);
    check("a_pred_ghr", 32'(b_pred_ghr), 32'h01);
    check("a_mp_count", b_mispredict_count, 32'd1);
    check("a_br_count", b_branch_count, 32'd1);

    // Four more taken resolves saturate the counter at 3
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_upd(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 2'd0);
      #1;
      check($sformatf("b_mispredict_%0d", i), 32'(b_mispredict), 32'd0);
    end

    // One not-taken: 3 -> 2, still predicted taken
    @(negedge clk);
    set_upd(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10, 2'd0);
    #1;
    check("nt_mispredict", 32'(b_mispredict), 32'd1);
    check("nt_redirect", b_redirect_pc, 32'h44);
    @(negedge clk);
    idle();
    #1;
    check("nt_pred_taken", 32'(b_pred_taken), 32'd1);
    check("nt_pred_target", b_pred_target, 32'h10);
    check("nt_pred_ghr", 32'(b_pred_ghr), 32'h3E);
    check("nt_br_count", b_branch_count, 32'd6);
    check("nt_mp_count", b_mispredict_count, 32'd2);

    // jal at 0x80 shares BTB entry 0 with 0x40 and evicts it
    @(negedge clk);
    set_upd(1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84, 2'd0);
    #1;
    check("jal_mispredict", 32'(b_mispredict), 32'd1);
    check("jal_redirect", b_redirect_pc, 32'h200);
    @(negedge clk);
    idle();
    if_pc = 32'h80;
    #1;
    check("jal_pred_taken", 32'(b_pred_taken), 32'd1);
    check("jal_pred_target", b_pred_target, 32'h200);
    if_pc = 32'h40;
    #1;
    check("alias_pred_taken", 32'(b_pred_taken), 32'd0);
    check("alias_pred_target", b_pred_target, 32'h44);

    // jalr at the same pc with a new target
    @(negedge clk);
    set_upd(1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 2'd0);
    if_pc = 32'h80;
    #1;
    check("jalr_mispredict", 32'(b_mispredict), 32'd1);
    check("jalr_redirect", b_redirect_pc, 32'h300);
    check("jalr_pre_update_target", b_pred_target, 32'h200);
    @(negedge clk);
    idle();
    #1;
    check("jalr_retrained", b_pred_target, 32'h300);
    check("jalr_br_count", b_branch_count, 32'd8);
    check("jalr_mp_count", b_mispredict_count, 32'd4);
    check("jalr_ghr_kept", 32'(b_pred_ghr), 32'h3E);

    // upd_valid with neither type bit: no mispredict, no state change
    @(negedge clk);
    set_upd(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0, 2'd0);
    #1;
    check("notype_mispredict", 32'(b_mispredict), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("notype_br_count", b_branch_count, 32'd8);
    check("notype_mp_count", b_mispredict_count, 32'd4);
    check("notype_target", b_pred_target, 32'h300);

    // Reset asserted together with a mispredicting update: reset wins
    @(negedge clk);
    rst = 1'b1;
    set_upd(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h44, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    if_pc = 32'h40;
    #1;
    check("rstupd_b_br_count", b_branch_count, 32'd0);
    check("rstupd_b_mp_count", b_mispredict_count, 32'd0);
    check("rstupd_b_ghr", 32'(b_pred_ghr), 32'd0);
    check("rstupd_b_pred_taken", 32'(b_pred_taken), 32'd0);
    check("rstupd_b_pred_target", b_pred_target, 32'h44);
    check("rstupd_g_mp_count", g_mispredict_count, 32'd0);
    check("rstupd_g_br_count", g_branch_count, 32'd0);
    check("rstupd_g_ghr", 32'(g_pred_ghr), 32'd0);

    // Gshare alternating pattern: correct from iteration 3 onward
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if_pc = 32'h100;
      set_upd(1'b1, 32'h100, 1'b1, 1'b0, gs_taken[k], 32'h500, gs_pred[k],
              gs_pred[k] ? 32'h500 : 32'h104, gs_ghr[k]);
      #1;
      check($sformatf("gs_pred_%0d", k), 32'(g_pred_taken), 32'(gs_pred[k]));
      check($sformatf("gs_ghr_%0d", k), 32'(g_pred_ghr), 32'(gs_ghr[k]));
      check($sformatf("gs_mispredict_%0d", k), 32'(g_mispredict), 32'(gs_mp[k]));
      if (k == 4) check("gs_pred_target", g_pred_target, 32'h500);
    end
    @(negedge clk);
    idle();
    #1;
    check("gs_br_count", g_branch_count, 32'd8);
    check("gs_mp_count", g_mispredict_count, 32'd2);
    check("gs_final_ghr", 32'(g_pred_ghr), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
